// File: rtl/bus_arbiter.sv
// Two-requester round-robin bus arbiter with a fixed 3-cycle IDLE/ACCESS/RESP transaction.
// Define ARB_LOCK_EN to add the r0_lock/r1_lock bus-retention inputs.
module bus_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
`ifdef ARB_LOCK_EN
    input  logic              r0_lock,
    input  logic              r1_lock,
`endif
    output logic              r0_gnt,
    output logic              r0_done,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r1_gnt,
    output logic              r1_done,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              en_load,
    output logic [ADDR_W-1:0] addr_load,
    input  logic [DATA_W-1:0] data_load,
    output logic              en_store,
    output logic [ADDR_W-1:0] addr_store,
    output logic [DATA_W-1:0] data_store
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state, state_next;

    logic              ptr;
    logic              owner;
    logic              we_q;
    logic              win;
    logic              keep_ptr;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        win        = r1_req;
        if (r0_req && r1_req) win = ptr;
        sel_we    = win ? r1_we    : r0_we;
        sel_addr  = win ? r1_addr  : r0_addr;
        sel_wdata = win ? r1_wdata : r0_wdata;
`ifdef ARB_LOCK_EN
        keep_ptr = owner ? r1_lock : r0_lock;
`else
        keep_ptr = 1'b0;
`endif
        case (state)
            IDLE:    if (r0_req || r1_req) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A held lock leaves the pointer on the owner; since the pointer breaks ties,
    // the owner keeps the bus until it drops lock or idles with req low.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= 1'b0;
            owner      <= 1'b0;
            we_q       <= 1'b0;
            r0_gnt     <= 1'b0;
            r1_gnt     <= 1'b0;
            r0_done    <= 1'b0;
            r1_done    <= 1'b0;
            r0_rdata   <= '0;
            r1_rdata   <= '0;
            en_load    <= 1'b0;
            en_store   <= 1'b0;
            addr_load  <= '0;
            addr_store <= '0;
            data_store <= '0;
        end else begin
            en_load  <= 1'b0;
            en_store <= 1'b0;
            r0_done  <= 1'b0;
            r1_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (r0_req || r1_req) begin
                        owner    <= win;
                        we_q     <= sel_we;
                        r0_gnt   <= ~win;
                        r1_gnt   <= win;
                        en_load  <= ~sel_we;
                        en_store <= sel_we;
                        if (sel_we) begin
                            addr_store <= sel_addr;
                            data_store <= sel_wdata;
                        end else begin
                            addr_load <= sel_addr;
                        end
                    end
                end
                ACCESS: begin
                    r0_done <= ~owner;
                    r1_done <= owner;
                    if (!we_q) begin
                        if (owner) r1_rdata <= data_load;
                        else       r0_rdata <= data_load;
                    end
                end
                RESP: begin
                    r0_gnt <= 1'b0;
                    r1_gnt <= 1'b0;
                    ptr    <= keep_ptr ? owner : ~owner;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed, table-driven bench for bus_arbiter; the lock sequence runs only with ARB_LOCK_EN.
module tb_bus_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              r0_req, r0_we, r1_req, r1_we;
    logic [ADDR_W-1:0] r0_addr, r1_addr;
    logic [DATA_W-1:0] r0_wdata, r1_wdata;
`ifdef ARB_LOCK_EN
    logic              r0_lock, r1_lock;
`endif
    logic              r0_gnt, r0_done, r1_gnt, r1_done;
    logic [DATA_W-1:0] r0_rdata, r1_rdata;
    logic              en_load, en_store;
    logic [ADDR_W-1:0] addr_load, addr_store;
    logic [DATA_W-1:0] data_load, data_store;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
`ifdef ARB_LOCK_EN
        .r0_lock(r0_lock), .r1_lock(r1_lock),
`endif
        .r0_gnt(r0_gnt), .r0_done(r0_done), .r0_rdata(r0_rdata),
        .r1_gnt(r1_gnt), .r1_done(r1_done), .r1_rdata(r1_rdata),
        .en_load(en_load), .addr_load(addr_load), .data_load(data_load),
        .en_store(en_store), .addr_store(addr_store), .data_store(data_store)
    );

    typedef struct {
        logic              q0, q1, we0, we1;
        logic [ADDR_W-1:0] a0, a1;
        logic [DATA_W-1:0] wd0, wd1, dl;
        logic              own, we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wd, rd0, rd1;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_gnt0"},  32'(r0_gnt),   32'd0);
        check({tag, "_gnt1"},  32'(r1_gnt),   32'd0);
        check({tag, "_done0"}, 32'(r0_done),  32'd0);
        check({tag, "_done1"}, 32'(r1_done),  32'd0);
        check({tag, "_enl"},   32'(en_load),  32'd0);
        check({tag, "_ens"},   32'(en_store), 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        r0_req = v.q0; r0_we = v.we0; r0_addr = v.a0; r0_wdata = v.wd0;
        r1_req = v.q1; r1_we = v.we1; r1_addr = v.a1; r1_wdata = v.wd1;
        data_load = v.dl;
        @(posedge clk); #1;  // ACCESS
        check("acc_gnt0",  32'(r0_gnt),   32'(v.own == 1'b0));
        check("acc_gnt1",  32'(r1_gnt),   32'(v.own == 1'b1));
        check("acc_enl",   32'(en_load),  32'(!v.we));
        check("acc_ens",   32'(en_store), 32'(v.we));
        check("acc_done",  32'({r0_done, r1_done}), 32'd0);
        if (v.we) begin
            check("acc_addr_store", 32'(addr_store), 32'(v.addr));
            check("acc_data_store", 32'(data_store), 32'(v.wd));
        end else begin
            check("acc_addr_load",  32'(addr_load),  32'(v.addr));
        end
        @(posedge clk); #1;  // RESP
        check("resp_done0", 32'(r0_done), 32'(v.own == 1'b0));
        check("resp_done1", 32'(r1_done), 32'(v.own == 1'b1));
        check("resp_gnt",   32'({r0_gnt, r1_gnt}), v.own ? 32'd1 : 32'd2);
        check("resp_en",    32'({en_load, en_store}), 32'd0);
        check("resp_rd0",   32'(r0_rdata), 32'(v.rd0));
        check("resp_rd1",   32'(r1_rdata), 32'(v.rd1));
        r0_req = 1'b0; r1_req = 1'b0;
        @(posedge clk); #1;  // IDLE
        check_idle("post");
    endtask

    initial begin
        vecs[0] = '{1, 0, 0, 0, 10'h005, 10'h000, 8'h00, 8'h00, 8'hA5, 0, 0, 10'h005, 8'h00, 8'hA5, 8'h00};
        vecs[1] = '{0, 1, 0, 1, 10'h000, 10'h3FF, 8'h00, 8'h3C, 8'hEE, 1, 1, 10'h3FF, 8'h3C, 8'hA5, 8'h00};
        vecs[2] = '{1, 1, 0, 1, 10'h010, 10'h020, 8'h00, 8'h22, 8'h11, 0, 0, 10'h010, 8'h00, 8'h11, 8'h00};
        vecs[3] = '{1, 1, 0, 1, 10'h010, 10'h020, 8'h00, 8'h22, 8'h33, 1, 1, 10'h020, 8'h22, 8'h11, 8'h00};
        vecs[4] = '{1, 1, 1, 0, 10'h100, 10'h200, 8'h55, 8'h00, 8'h77, 0, 1, 10'h100, 8'h55, 8'h11, 8'h00};
        vecs[5] = '{1, 1, 1, 0, 10'h100, 10'h200, 8'h55, 8'h00, 8'h77, 1, 0, 10'h200, 8'h00, 8'h11, 8'h77};
        vecs[6] = '{0, 1, 0, 0, 10'h000, 10'h001, 8'h00, 8'h00, 8'h99, 1, 0, 10'h001, 8'h00, 8'h11, 8'h99};
        vecs[7] = '{1, 1, 0, 1, 10'h3FF, 10'h123, 8'h00, 8'h44, 8'hFF, 0, 0, 10'h3FF, 8'h00, 8'hFF, 8'h99};

        rst = 1'b1;
        r0_req = 0; r0_we = 0; r0_addr = '0; r0_wdata = '0;
        r1_req = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0;
        data_load = '0;
`ifdef ARB_LOCK_EN
        r0_lock = 0; r1_lock = 0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("rst");
        check("rst_addr_load",  32'(addr_load),  32'd0);
        check("rst_addr_store", 32'(addr_store), 32'd0);
        check("rst_data_store", 32'(data_store), 32'd0);
        check("rst_rd0",        32'(r0_rdata),   32'd0);
        check("rst_rd1",        32'(r1_rdata),   32'd0);
        rst = 1'b0;

        // Reset during ACCESS of an r0 load aborts it.
        @(negedge clk);
        r0_req = 1; r0_we = 0; r0_addr = 10'h005; data_load = 8'hA5;
        @(posedge clk); #1;
        check("abort_acc_enl", 32'(en_load), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_done0", 32'(r0_done),  32'd0);
        check("abort_rd0",   32'(r0_rdata), 32'd0);
        check("abort_gnt0",  32'(r0_gnt),   32'd0);
        check("abort_en",    32'({en_load, en_store}), 32'd0);
        rst = 1'b0; r0_req = 0;
        @(posedge clk); #1;
        check_idle("abort_next");

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Request dropped during ACCESS still completes.
        @(negedge clk);
        r1_req = 1; r1_we = 1; r1_addr = 10'h0AA; r1_wdata = 8'h5A; data_load = 8'hC3;
        @(posedge clk); #1;
        check("drop_ens",  32'(en_store),   32'd1);
        check("drop_addr", 32'(addr_store), 32'h0AA);
        check("drop_data", 32'(data_store), 32'h5A);
        r1_req = 0;
        @(posedge clk); #1;
        check("drop_done1", 32'(r1_done),  32'd1);
        check("drop_rd1",   32'(r1_rdata), 32'h99);
        @(posedge clk); #1;
        check_idle("drop_post");

`ifdef ARB_LOCK_EN
        @(negedge clk);
        r0_req = 1; r0_we = 0; r0_addr = 10'h040; r0_lock = 1;
        r1_req = 1; r1_we = 0; r1_addr = 10'h041; data_load = 8'h66;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("lock_gnt0", 32'(r0_gnt), 32'(i < 3));
            check("lock_gnt1", 32'(r1_gnt), 32'(i >= 3));
            check("lock_both", 32'(r0_gnt & r1_gnt), 32'd0);
            @(posedge clk); #1;
            check("lock_done0", 32'(r0_done), 32'(i < 3));
            check("lock_done1", 32'(r1_done), 32'(i >= 3));
            if (i == 2) r0_req = 0;
            if (i == 3) begin r1_req = 0; r0_lock = 0; end
            @(posedge clk); #1;
        end
        check_idle("lock_post");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, SHALL set the width of the address in bits.
REQ-002 Parameter DATA_W, default 8, SHALL set the width of the data in bits.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on the posedge.
REQ-004 rst  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 rN_req  in  1  SHALL request a transaction from requester N, N∈{0,1}; held high until rN_done.
REQ-006 rN_we  in  1  SHALL select the access type: 1=store, 0=load; sampled with rN_req.
REQ-007 rN_addr  in  ADDR_W  SHALL carry the transaction address.
REQ-008 rN_wdata  in  DATA_W  SHALL carry the store data.
REQ-009 rN_gnt  out  1  SHALL be high while requester N owns the bus (ACCESS and RESP).
REQ-010 rN_done  out  1  SHALL pulse for one cycle when N's transaction completes.
REQ-011 rN_rdata  out  DATA_W  SHALL carry load data, held until N's next load completes.
REQ-012 en_load/addr_load  out  1/ADDR_W  SHALL drive the downstream load strobe and address.
REQ-013 data_load  in  DATA_W  SHALL carry the downstream load data, valid during the ACCESS cycle.
REQ-014 en_store/addr_store/data_store  out  1/ADDR_W/DATA_W  SHALL drive the downstream store port.
REQ-015 rN_lock  in  1  SHALL be present only with ARB_LOCK_EN and request bus retention.

Function
REQ-016 The FSM SHALL have three states, IDLE, ACCESS and RESP, with transitions as follows:
- IDLE->ACCESS when any rN_req=1.
- ACCESS->RESP unconditionally.
- RESP->IDLE unconditionally.
REQ-017 In IDLE, the winner SHALL be chosen as follows:
- If only one request is pending, it wins.
- If both are pending, the requester indicated by the priority pointer wins.
REQ-018 On the winner, the block SHALL register that requester's we/addr/wdata and its index.
REQ-019 Bus outputs SHALL be registered, and en_load or en_store SHALL be high for exactly the one ACCESS cycle.
REQ-020 Bus enable polarity SHALL follow the access type:
- store: en_store=1, en_load=0.
- load: en_load=1, en_store=0.
- Both enables are 0 in IDLE and RESP.
REQ-021 For a load, data_load SHALL be captured into the winner's rdata at the posedge that ends ACCESS.
REQ-022 rN_done SHALL be high only in RESP, and only for the granted requester; a store leaves rN_rdata unchanged.
REQ-023 Latency SHALL be fixed: req sampled at edge k -> bus strobe in cycle k+1 -> done in cycle k+2; one transaction per 3 cycles.
REQ-024 The requester SHALL drop req at the edge ending RESP; the arbiter SHALL ignore req in ACCESS/RESP.
REQ-025 A req that falls during ACCESS SHALL NOT abort the transaction, which completes normally.
REQ-026 The priority pointer SHALL point to the non-winner after every completed transaction (round-robin).
REQ-027 The request inputs SHALL NOT be modified; an addr change while not granted has no effect.

Reset
REQ-028 While rst=1 at a posedge, all state SHALL reset:
- state=IDLE, pointer=0.
- All enables, gnt and done = 0.
- addr_*, data_store and rN_rdata = 0.
REQ-029 rst asserted during ACCESS or RESP SHALL abort the transaction, with no done pulse and no rdata update.

Configuration
REQ-030 With ARB_LOCK_EN defined, the rN_lock ports SHALL exist and locking SHALL apply:
- If rN_lock=1 when N's transaction completes, the pointer stays on N.
- The other requester is not granted until N releases (lock=0 at completion or req=0 in IDLE).
REQ-031 Without ARB_LOCK_EN, the lock ports SHALL be absent and arbitration SHALL be pure round-robin per REQ-026.

Verification
REQ-032 r0 load from addr 0x005, with data_load=0xA5 during ACCESS -> en_load one cycle with addr_load=0x005; r0_done at k+2; r0_rdata=0xA5.
REQ-033 r1 store 0x3C to 0x3FF -> en_store one cycle with addr_store=0x3FF, data_store=0x3C; r1_done at k+2; r1_rdata unchanged.
REQ-034 r0 and r1 request simultaneously after reset, repeatedly -> grant order r0, r1, r0, r1; never both gnt high.
REQ-035 rst asserted during ACCESS of an r0 load -> no r0_done; r0_rdata stays 0; next cycle idle with all enables 0.
REQ-036 With ARB_LOCK_EN, r0_lock=1 for 3 transactions while r1_req is held -> r0 is granted 3 times, then r1.
